// File: rtl/axi_read_burst_dma.sv
// axi_read_burst_dma: AXI4 read-only burst DMA engine.
// Accepts a request (start address, beat count minus one), splits it into INCR bursts
// bounded by MAX_BURST and the address-space wrap, issues them one at a time on AR, and
// streams the R data through an internal FIFO to a valid/ready output tagged with last.
//
// Optional feature macro: AXI_READ_BURST_DMA_4K_SPLIT_EN -- when defined, bursts are also
// split so that none crosses a 4 KiB address boundary.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake; req_addr start byte address,
//                                   req_len beat count minus one
//   busy                            engine active or FIFO holding data
//   err                             sticky error, cleared by reset or next request accept
//   axi_ar*                         AXI read address channel (master side)
//   axi_r*                          AXI read data channel (master side)
//   out_valid/out_ready             output stream handshake; out_data, out_last
module axi_read_burst_dma #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned ID_VALUE   = 0,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_len,
    output logic              busy,
    output logic              err,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    output logic [ID_W-1:0]   axi_arid,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic [7:0]        axi_arlen,
    output logic [1:0]        axi_arsize,
    output logic [1:0]        axi_arburst,
    output logic [1:0]        axi_arlock,
    output logic [3:0]        axi_arcache,
    output logic [2:0]        axi_arprot,
    output logic [3:0]        axi_arqos,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    input  logic [ID_W-1:0]   axi_rid,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StAddr, StData} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [16:0]        remaining_q, remaining_d;
    logic [8:0]         beats_left_q, beats_left_d;
    logic [ADDR_W-1:0]  araddr_q, araddr_d;
    logic [7:0]         arlen_q, arlen_d;
    logic               err_q, err_d;
    logic               req_ready_q, arvalid_q, rready_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W:0]    mem_q [FIFO_DEPTH];

    logic               push, push_last, pop, r_fire, last_beat;
    logic [31:0]        addr_ext, beat_idx, to_wrap, burst, free;
`ifdef AXI_READ_BURST_DMA_4K_SPLIT_EN
    logic [31:0]        to_4k;
`endif

    // Burst size for the current address: never past the remaining count, MAX_BURST, or
    // the top of the address space (wrap is treated as a boundary).
    always_comb begin
        addr_ext = 32'(addr_q);
        beat_idx = addr_ext >> SIZE;
        to_wrap  = (32'd1 << (ADDR_W - SIZE)) - beat_idx;
        burst    = 32'(remaining_q);
        if (burst > 32'(MAX_BURST)) burst = 32'(MAX_BURST);
        if (burst > to_wrap)        burst = to_wrap;
`ifdef AXI_READ_BURST_DMA_4K_SPLIT_EN
        to_4k = (32'd4096 - (addr_ext & 32'h0000_0FFF)) >> SIZE;
        if (burst > to_4k)          burst = to_4k;
`endif
        free = 32'(FIFO_DEPTH) - 32'(count_q);
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        beats_left_d = beats_left_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        err_d        = err_q;
        push         = 1'b0;
        push_last    = 1'b0;
        r_fire       = axi_rvalid && rready_q;
        last_beat    = (beats_left_q == 9'd1);
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    remaining_d = 17'(req_len) + 17'd1;
                    err_d       = 1'b0;
                    state_d     = StCalc;
                end
            end
            StCalc: begin
                // One burst in flight at a time and the previous one has fully landed by
                // now, so the only reservation needed is this burst's beats.
                if (burst <= free) begin
                    araddr_d     = addr_q;
                    arlen_d      = 8'(burst - 32'd1);
                    beats_left_d = 9'(burst);
                    state_d      = StAddr;
                end
            end
            StAddr: begin
                if (axi_arready) state_d = StData;
            end
            StData: begin
                if (r_fire) begin
                    push         = 1'b1;
                    push_last    = (remaining_q == 17'd1);
                    addr_d       = addr_q + ADDR_W'(BYTES);
                    remaining_d  = remaining_q - 17'd1;
                    beats_left_d = beats_left_q - 9'd1;
                    // rlast must coincide with our own beat count; bad beats still pass on.
                    if ((last_beat != axi_rlast) || (axi_rresp != 2'b00) ||
                        (axi_rid != ID_W'(ID_VALUE))) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) state_d = (remaining_d == 17'd0) ? StIdle : StCalc;
                end
            end
            default: state_d = StIdle;
        endcase

        pop      = (count_q != '0) && out_ready;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            remaining_q  <= '0;
            beats_left_q <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            beats_left_q <= beats_left_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            err_q        <= err_d;
            req_ready_q  <= (state_d == StIdle);
            arvalid_q    <= (state_d == StAddr);
            rready_q     <= (state_d == StData);
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {push_last, axi_rdata};
    end

    assign req_ready   = req_ready_q;
    assign busy        = (state_q != StIdle) || (count_q != '0);
    assign err         = err_q;
    assign axi_arvalid = arvalid_q;
    assign axi_arid    = ID_W'(ID_VALUE);
    assign axi_araddr  = araddr_q;
    assign axi_arlen   = arlen_q;
    assign axi_arsize  = 2'(SIZE);
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 2'b00;
    assign axi_arcache = 4'b0000;
    assign axi_arprot  = 3'b000;
    assign axi_arqos   = 4'b0000;
    assign axi_rready  = rready_q;
    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q][DATA_W-1:0];
    assign out_last    = out_valid && mem_q[rd_ptr_q][DATA_W];

endmodule

// File: tb/tb_axi_read_burst_dma.sv
`timescale 1ns/1ps
module tb_axi_read_burst_dma;
    localparam int unsigned ADDR_W = 16, DATA_W = 8, ID_W = 4, ID_VALUE = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid, req_ready, busy, err;
    logic [15:0] req_addr, req_len;
    logic axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
    logic [ID_W-1:0] axi_arid, axi_rid;
    logic [15:0] axi_araddr;
    logic [7:0] axi_arlen, axi_rdata;
    logic [1:0] axi_arsize, axi_arburst, axi_arlock, axi_rresp;
    logic [3:0] axi_arcache, axi_arqos;
    logic [2:0] axi_arprot;
    logic out_valid, out_ready, out_last;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    axi_read_burst_dma #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .ID_VALUE(ID_VALUE),
        .MAX_BURST(16), .FIFO_DEPTH(32)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .busy(busy), .err(err),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
        .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    typedef struct {
        logic [15:0]      addr;
        logic [15:0]      len;
        int               nar;
        logic [2:0][15:0] ar_addr;
        logic [2:0][7:0]  ar_len;
    } vec_t;
    typedef struct packed { logic [15:0] addr; logic [7:0] len; } ar_t;
    typedef struct packed { logic [7:0] data; logic last; } beat_t;

    ar_t   ar_exp_q[$];
    beat_t out_exp_q[$];
    vec_t  vecs[5];

    int n_checks = 0;
    int n_fail = 0;

    // Slave model state
    logic [15:0] r_addr = '0;
    int r_left = 0, r_idx = 0, beats_sent = 0, ar_count = 0;
    int r_stop_after = 32'h7fff_ffff;
    int resp_bad_idx = -1;
    bit drop_rlast = 1'b0;
    bit err_expect_next = 1'b0;

    // Consumer: 0 stall, 1 always ready, 2 pop budget, 3 random
    int out_mode = 1;
    int pop_budget = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] l, input int n,
                                input logic [15:0] a0, input logic [7:0] l0,
                                input logic [15:0] a1, input logic [7:0] l1,
                                input logic [15:0] a2, input logic [7:0] l2);
        vec_t v;
        v.addr = a; v.len = l; v.nar = n;
        v.ar_addr[0] = a0; v.ar_len[0] = l0;
        v.ar_addr[1] = a1; v.ar_len[1] = l1;
        v.ar_addr[2] = a2; v.ar_len[2] = l2;
        return v;
    endfunction

    task automatic push_beats(input logic [15:0] a, input logic [15:0] l);
        for (int i = 0; i <= int'(l); i++) begin
            logic [15:0] ba;
            ba = a + 16'(i);
            out_exp_q.push_back('{data: mem_f(ba), last: (i == int'(l))});
        end
    endtask

    task automatic push_ar(input logic [15:0] a, input logic [7:0] l);
        ar_exp_q.push_back('{addr: a, len: l});
    endtask

    task automatic do_req(input logic [15:0] a, input logic [15:0] l);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 1000) begin @(negedge clk); t++; end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_addr = a; req_len = l; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((busy || out_exp_q.size() != 0 || ar_exp_q.size() != 0) && t < 3000) begin
            @(negedge clk); t++;
        end
        check({name, "_done"}, {31'd0, t < 3000}, 32'd1);
    endtask

    // AXI slave: random ready/valid, data derived from byte address, error injection.
    initial begin
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rid = '0; axi_rdata = '0;
        axi_rresp = '0; axi_rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (err_expect_next) begin
                check("err_after_bad_beat", {31'd0, err}, 32'd1);
                err_expect_next = 1'b0;
            end
            if (r_left > 0 && beats_sent < r_stop_after && $urandom_range(0, 3) != 0) begin
                axi_rvalid = 1'b1;
                axi_rdata  = mem_f(r_addr);
                axi_rlast  = (r_left == 1) && !drop_rlast;
                axi_rresp  = (r_idx == resp_bad_idx) ? 2'd2 : 2'd0;
                axi_rid    = ID_W'(ID_VALUE);
            end else begin
                axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'd0;
            end
            if (axi_rvalid && axi_rready && !reset) begin
                if (axi_rresp != 2'd0) begin
                    check("err_before_bad_beat", {31'd0, err}, 32'd0);
                    err_expect_next = 1'b1;
                end
                r_addr++; r_left--; r_idx++; beats_sent++;
            end
            axi_arready = ($urandom_range(0, 2) != 0);
            if (axi_arvalid && axi_arready && !reset) begin
                ar_count++;
                if (ar_exp_q.size() == 0) begin
                    check("ar_unexpected", 32'(ar_exp_q.size()), 32'd1);
                end else begin
                    ar_t e;
                    e = ar_exp_q.pop_front();
                    check("araddr", {16'd0, axi_araddr}, {16'd0, e.addr});
                    check("arlen", {24'd0, axi_arlen}, {24'd0, e.len});
                    check("arsize_arburst", {28'd0, axi_arsize, axi_arburst}, 32'h1);
                end
                r_addr = axi_araddr; r_left = int'(axi_arlen) + 1; r_idx = 0;
            end
        end
    end

    // Output consumer and scoreboard
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (out_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                2:       out_ready = (pop_budget > 0);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (out_valid && out_ready && !reset) begin
                if (out_mode == 2) pop_budget--;
                if (out_exp_q.size() == 0) begin
                    check("out_unexpected", 32'(out_exp_q.size()), 32'd1);
                end else begin
                    beat_t b;
                    b = out_exp_q.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, b.data});
                    check("out_last", {31'd0, out_last}, {31'd0, b.last});
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit seen;
        req_valid = 1'b0; req_addr = '0; req_len = '0;
        vecs[0] = mk(16'h0010, 16'd3, 1, 16'h0010, 8'd3, 16'h0, 8'd0, 16'h0, 8'd0);
        vecs[1] = mk(16'h0000, 16'd39, 3, 16'h0000, 8'd15, 16'h0010, 8'd15, 16'h0020, 8'd7);
`ifdef AXI_READ_BURST_DMA_4K_SPLIT_EN
        vecs[2] = mk(16'h0FFC, 16'd7, 2, 16'h0FFC, 8'd3, 16'h1000, 8'd3, 16'h0, 8'd0);
`else
        vecs[2] = mk(16'h0FFC, 16'd7, 1, 16'h0FFC, 8'd7, 16'h0, 8'd0, 16'h0, 8'd0);
`endif
        vecs[3] = mk(16'hFFF8, 16'd15, 2, 16'hFFF8, 8'd7, 16'h0000, 8'd7, 16'h0, 8'd0);
        vecs[4] = mk(16'h0123, 16'd0, 1, 16'h0123, 8'd0, 16'h0, 8'd0, 16'h0, 8'd0);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_arvalid", {31'd0, axi_arvalid}, 32'd0);
        check("rst_rready", {31'd0, axi_rready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_araddr", {16'd0, axi_araddr}, 32'd0);
        check("rst_arlen", {24'd0, axi_arlen}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            out_mode = (i == 0) ? 1 : 3;
            base = ar_count;
            for (int k = 0; k < vecs[i].nar; k++) push_ar(vecs[i].ar_addr[k], vecs[i].ar_len[k]);
            push_beats(vecs[i].addr, vecs[i].len);
            do_req(vecs[i].addr, vecs[i].len);
            if (i == 0) begin
                int t = 0;
                check("arvalid_t1", {31'd0, axi_arvalid}, 32'd0);
                @(negedge clk);
                check("arvalid_t2", {31'd0, axi_arvalid}, 32'd1);
                while (!(out_valid && out_last) && t < 500) begin @(negedge clk); t++; end
                check("busy_at_last_pop", {31'd0, busy}, 32'd1);
                @(negedge clk);
                check("busy_after_last_pop", {31'd0, busy}, 32'd0);
            end
            wait_done($sformatf("vec%0d", i));
            check($sformatf("vec%0d_ar_count", i), 32'(ar_count - base), 32'(vecs[i].nar));
            check($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
        end

        // Back-pressure: FIFO fills after two bursts, third AR waits for room.
        out_mode = 0;
        base = ar_count;
        for (int k = 0; k < 4; k++) push_ar(16'h0400 + 16'(16 * k), 8'd15);
        push_beats(16'h0400, 16'd63);
        do_req(16'h0400, 16'd63);
        repeat (150) @(negedge clk);
        check("bp_ar_count", 32'(ar_count - base), 32'd2);
        check("bp_no_arvalid", {31'd0, axi_arvalid}, 32'd0);
        pop_budget = 16;
        out_mode = 2;
        begin
            int t = 0;
            while (pop_budget > 0 && t < 500) begin @(negedge clk); t++; end
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (axi_arvalid || (ar_count - base) >= 3) seen = 1'b1;
        end
        check("bp_ar_after_pops", {31'd0, seen}, 32'd1);
        out_mode = 1;
        wait_done("bp");
        check("bp_ar_total", 32'(ar_count - base), 32'd4);

        // Error response on beat 2 of 4.
        out_mode = 1;
        resp_bad_idx = 1;
        push_ar(16'h0500, 8'd3);
        push_beats(16'h0500, 16'd3);
        do_req(16'h0500, 16'd3);
        wait_done("rresp");
        check("rresp_err_sticky", {31'd0, err}, 32'd1);
        resp_bad_idx = -1;

        // Next accept clears err; missing rlast sets it again.
        drop_rlast = 1'b1;
        push_ar(16'h0600, 8'd3);
        push_beats(16'h0600, 16'd3);
        do_req(16'h0600, 16'd3);
        check("err_cleared_on_accept", {31'd0, err}, 32'd0);
        wait_done("nolast");
        check("nolast_err", {31'd0, err}, 32'd1);
        drop_rlast = 1'b0;

        // Reset mid-burst with three beats buffered.
        out_mode = 0;
        r_stop_after = beats_sent + 3;
        push_ar(16'h0200, 8'd15);
        do_req(16'h0200, 16'd15);
        begin
            int t = 0;
            while (beats_sent < r_stop_after && t < 500) begin @(negedge clk); t++; end
        end
        @(negedge clk);
        check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_rready", {31'd0, axi_rready}, 32'd1);
        reset = 1'b1;
        r_left = 0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rready", {31'd0, axi_rready}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        out_exp_q.delete();
        ar_exp_q.delete();
        r_stop_after = 32'h7fff_ffff;
        @(negedge clk);
        check("midrst_req_ready_after", {31'd0, req_ready}, 32'd1);

        // Recovery after reset.
        out_mode = 3;
        push_ar(16'h0300, 8'd2);
        push_beats(16'h0300, 16'd2);
        do_req(16'h0300, 16'd2);
        wait_done("recover");
        check("recover_err", {31'd0, err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
